// File: rtl/mem_port_arbiter.sv
// Arbitrates the single synchronous memory port between instruction fetch and the LSU.
// It also handles byte lanes: store strobes/replication and load extraction/extension.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_req,
    input  logic [XLEN-1:0] fetch_addr,
    output logic            fetch_ack,
    output logic            fetch_err,
    output logic [XLEN-1:0] fetch_rdata,
    input  logic            lsu_req,
    input  logic            lsu_we,
    input  logic [1:0]      lsu_width,
    input  logic            lsu_unsigned,
    input  logic [XLEN-1:0] lsu_addr,
    input  logic [XLEN-1:0] lsu_wdata,
    output logic            lsu_ack,
    output logic            lsu_err,
    output logic [XLEN-1:0] lsu_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    // Handshake: a requester holds req (and its operands) until it sees a one-cycle ack;
    // req is sampled only in IDLE, ack comes one cycle after the grant, and a req still
    // high two cycles after the grant is a new request.
    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   starve_cnt;

    logic            win_lsu_q;
    logic            err_q;
    logic [1:0]      off_q;
    logic [1:0]      width_q;
    logic            uns_q;
    logic            we_q;

    logic            fetch_bad;
    logic            lsu_bad;
    logic            grant_fetch;
    logic            grant_lsu;
    logic            issue;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;

    assign fetch_bad = (fetch_addr[1:0] != 2'b00);
    assign lsu_bad   = (lsu_width == 2'd3) ||
                       (lsu_width == 2'd1 && lsu_addr[0]) ||
                       (lsu_width == 2'd2 && lsu_addr[1:0] != 2'b00);

    // LSU wins contention unless fetch has been locked out STARVE_LIMIT times in a row.
    assign grant_fetch = fetch_req && (!lsu_req || starve_cnt == LIMIT);
    assign grant_lsu   = lsu_req && !grant_fetch;
    assign issue       = (state == IDLE) && !rst && (grant_fetch || grant_lsu);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (fetch_req || lsu_req) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_lsu_q  <= 1'b0;
            err_q      <= 1'b0;
            off_q      <= 2'b00;
            width_q    <= 2'b00;
            uns_q      <= 1'b0;
            we_q       <= 1'b0;
            starve_cnt <= '0;
        end else if (state == IDLE && (grant_fetch || grant_lsu)) begin
            win_lsu_q <= grant_lsu;
            err_q     <= grant_lsu ? lsu_bad : fetch_bad;
            off_q     <= grant_lsu ? lsu_addr[1:0] : 2'b00;
            width_q   <= grant_lsu ? lsu_width : 2'd2;
            uns_q     <= grant_lsu & lsu_unsigned;
            we_q      <= grant_lsu & lsu_we;
            if (grant_fetch || !fetch_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign shifted = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (width_q)
            2'd0:    load_data = {{(XLEN-8){shifted[7] & ~uns_q}}, shifted[7:0]};
            2'd1:    load_data = {{(XLEN-16){shifted[15] & ~uns_q}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_wstrb   = 4'b0000;
        mem_addr    = '0;
        mem_wdata   = '0;
        fetch_ack   = 1'b0;
        fetch_err   = 1'b0;
        fetch_rdata = '0;
        lsu_ack     = 1'b0;
        lsu_err     = 1'b0;
        lsu_rdata   = '0;
        if (issue && grant_fetch && !fetch_bad) begin
            mem_en   = 1'b1;
            mem_addr = {fetch_addr[XLEN-1:2], 2'b00};
        end else if (issue && grant_lsu && !lsu_bad) begin
            mem_en   = 1'b1;
            mem_we   = lsu_we;
            mem_addr = {lsu_addr[XLEN-1:2], 2'b00};
            if (lsu_we) begin
                case (lsu_width)
                    2'd0: begin
                        mem_wstrb = 4'b0001 << lsu_addr[1:0];
                        mem_wdata = {4{lsu_wdata[7:0]}};
                    end
                    2'd1: begin
                        mem_wstrb = lsu_addr[1] ? 4'b1100 : 4'b0011;
                        mem_wdata = {2{lsu_wdata[15:0]}};
                    end
                    default: begin
                        mem_wstrb = 4'b1111;
                        mem_wdata = lsu_wdata;
                    end
                endcase
            end
        end
        if (state == RESP) begin
            fetch_ack = !win_lsu_q;
            fetch_err = !win_lsu_q && err_q;
            lsu_ack   = win_lsu_q;
            lsu_err   = win_lsu_q && err_q;
            if (!win_lsu_q && !err_q) fetch_rdata = mem_rdata;
            if (win_lsu_q && !err_q && !we_q) lsu_rdata = load_data;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory, per-feature tasks, expected-result queues.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic        fetch_err;
    logic [31:0] fetch_rdata;
    logic        lsu_req;
    logic        lsu_we;
    logic [1:0]  lsu_width;
    logic        lsu_unsigned;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_ack;
    logic        lsu_err;
    logic [31:0] lsu_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [0:0]  err_q[$];
    logic [0:0]  grant_q[$];

    mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .fetch_err(fetch_err), .fetch_rdata(fetch_rdata),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_width(lsu_width),
        .lsu_unsigned(lsu_unsigned), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_ack(lsu_ack), .lsu_err(lsu_err), .lsu_rdata(lsu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Synchronous memory: reset reloads the image (word 0x100 = 0x8899AABB).
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[64]   <= 32'h8899AABB;
            mem_rdata <= 32'h0;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    task automatic lsu_op(input logic we, input logic [1:0] width, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        logic [31:0] e;
        logic [0:0] ee;
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = we; lsu_width = width; lsu_unsigned = uns;
        lsu_addr = addr; lsu_wdata = wdata;
        exp_q.push_back(exp_rdata);
        err_q.push_back(exp_err);
        #1;
        checks++;
        if (mem_en !== !exp_err) begin
            errors++; $display("FAIL lsu_issue_en addr=%h got=%b exp=%b", addr, mem_en, !exp_err);
        end
        if (!exp_err) begin
            checks++;
            if ({mem_we, mem_wstrb, mem_addr} !== {we, exp_wstrb, addr[31:2], 2'b00}) begin
                errors++;
                $display("FAIL lsu_issue_ctl addr=%h got we=%b strb=%b maddr=%h exp we=%b strb=%b",
                         addr, mem_we, mem_wstrb, mem_addr, we, exp_wstrb);
            end
            if (we) begin
                checks++;
                if (mem_wdata !== exp_wdata) begin
                    errors++; $display("FAIL lsu_wdata addr=%h got=%h exp=%h", addr, mem_wdata, exp_wdata);
                end
            end
        end
        n = 0;
        @(negedge clk);
        while (lsu_ack !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (lsu_ack !== 1'b1) begin
            errors++; $display("FAIL lsu_ack_timeout addr=%h got=%b exp=1", addr, lsu_ack);
            exp_q.delete(); err_q.delete();
        end else begin
            e  = exp_q.pop_front();
            ee = err_q.pop_front();
            checks++;
            if (lsu_err !== ee) begin
                errors++; $display("FAIL lsu_err addr=%h got=%b exp=%b", addr, lsu_err, ee);
            end
            if (!we && !ee) begin
                checks++;
                if (lsu_rdata !== e) begin
                    errors++; $display("FAIL lsu_rdata addr=%h got=%h exp=%h", addr, lsu_rdata, e);
                end
            end
        end
        lsu_req = 1'b0;
    endtask

    task automatic fetch_op(input logic [31:0] addr, input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        logic [31:0] e;
        logic [0:0] ee;
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = addr;
        exp_q.push_back(exp_rdata);
        err_q.push_back(exp_err);
        #1;
        checks++;
        if ({mem_en, mem_we, mem_wstrb} !== {!exp_err, 1'b0, 4'b0000}) begin
            errors++; $display("FAIL fetch_issue addr=%h got en=%b we=%b strb=%b exp en=%b",
                               addr, mem_en, mem_we, mem_wstrb, !exp_err);
        end
        n = 0;
        @(negedge clk);
        while (fetch_ack !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (fetch_ack !== 1'b1) begin
            errors++; $display("FAIL fetch_ack_timeout addr=%h got=%b exp=1", addr, fetch_ack);
            exp_q.delete(); err_q.delete();
        end else begin
            e  = exp_q.pop_front();
            ee = err_q.pop_front();
            checks++;
            if (fetch_err !== ee) begin
                errors++; $display("FAIL fetch_err addr=%h got=%b exp=%b", addr, fetch_err, ee);
            end
            if (!ee) begin
                checks++;
                if (fetch_rdata !== e) begin
                    errors++; $display("FAIL fetch_rdata addr=%h got=%h exp=%h", addr, fetch_rdata, e);
                end
            end
        end
        fetch_req = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({fetch_ack, fetch_err, fetch_rdata, lsu_ack, lsu_err, lsu_rdata,
             mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL %s got fack=%b lack=%b men=%b mwe=%b strb=%b maddr=%h frd=%h lrd=%h exp all 0",
                     name, fetch_ack, lsu_ack, mem_en, mem_we, mem_wstrb, mem_addr, fetch_rdata, lsu_rdata);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        fetch_req = 1'b1; fetch_addr = 32'h100;
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_width = 2'd2; lsu_unsigned = 1'b0;
        lsu_addr = 32'h104; lsu_wdata = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        fetch_req = 1'b0; lsu_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle_outputs");
    endtask

    task automatic test_loads;
        lsu_op(0, 2'd0, 0, 32'h103, 0, 4'b0000, 0, 32'hFFFFFF88, 0);
        lsu_op(0, 2'd0, 1, 32'h103, 0, 4'b0000, 0, 32'h00000088, 0);
        lsu_op(0, 2'd1, 1, 32'h102, 0, 4'b0000, 0, 32'h00008899, 0);
        lsu_op(0, 2'd1, 0, 32'h102, 0, 4'b0000, 0, 32'hFFFF8899, 0);
        lsu_op(0, 2'd0, 0, 32'h100, 0, 4'b0000, 0, 32'hFFFFFFBB, 0);
        lsu_op(0, 2'd0, 1, 32'h101, 0, 4'b0000, 0, 32'h000000AA, 0);
        lsu_op(0, 2'd1, 0, 32'h100, 0, 4'b0000, 0, 32'hFFFFAABB, 0);
        lsu_op(0, 2'd2, 0, 32'h100, 0, 4'b0000, 0, 32'h8899AABB, 0);
    endtask

    task automatic test_lsu_errors;
        lsu_op(0, 2'd1, 0, 32'h101, 0, 4'b0000, 0, 32'h0, 1);
        lsu_op(0, 2'd2, 0, 32'h102, 0, 4'b0000, 0, 32'h0, 1);
        lsu_op(0, 2'd3, 0, 32'h100, 0, 4'b0000, 0, 32'h0, 1);
        lsu_op(1, 2'd1, 0, 32'h103, 32'h0000FFFF, 4'b0000, 0, 32'h0, 1);
    endtask

    task automatic test_stores;
        lsu_op(1, 2'd0, 0, 32'h101, 32'h000000CC, 4'b0010, 32'hCCCCCCCC, 0, 0);
        lsu_op(1, 2'd1, 0, 32'h102, 32'h00001234, 4'b1100, 32'h12341234, 0, 0);
        lsu_op(1, 2'd2, 0, 32'h104, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 0, 0);
        lsu_op(0, 2'd2, 0, 32'h100, 0, 4'b0000, 0, 32'h1234CCBB, 0);
        lsu_op(0, 2'd0, 0, 32'h101, 0, 4'b0000, 0, 32'hFFFFFFCC, 0);
    endtask

    task automatic test_fetch;
        fetch_op(32'h104, 32'hDEADBEEF, 0);
        fetch_op(32'h006, 32'h0, 1);
        fetch_op(32'h100, 32'h1234CCBB, 0);
    endtask

    task automatic test_starve;
        logic [0:0] g;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) grant_q.push_back(1'b1);
            grant_q.push_back(1'b0);
        end
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 32'h100;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_width = 2'd2; lsu_unsigned = 1'b0; lsu_addr = 32'h104;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fetch_ack || lsu_ack) begin
                checks++;
                if (fetch_ack && lsu_ack) begin
                    errors++; $display("FAIL starve_dual_ack cycle=%0d got both acks exp one", i);
                end else if (grant_q.size() == 0) begin
                    errors++; $display("FAIL starve_extra_grant cycle=%0d got lsu=%b exp none", i, lsu_ack);
                end else begin
                    g = grant_q.pop_front();
                    if (lsu_ack !== g) begin
                        errors++; $display("FAIL starve_order cycle=%0d got lsu=%b exp lsu=%b", i, lsu_ack, g);
                    end
                end
            end
        end
        checks++;
        if (grant_q.size() != 0) begin
            errors++; $display("FAIL starve_missing_grants got_left=%0d exp=0", grant_q.size());
            grant_q.delete();
        end
        fetch_req = 1'b0; lsu_req = 1'b0;
    endtask

    task automatic test_reset_in_resp;
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 32'h100;
        @(posedge clk);
        #1;
        rst = 1'b1; fetch_req = 1'b0;
        #1;
        check_all_zero("reset_in_resp");
        repeat (2) begin
            @(negedge clk);
            if (fetch_ack) seen = 1'b1;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (fetch_ack) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL reset_dropped_ack got ack=1 exp ack=0");
        end
        fetch_op(32'h100, 32'h8899AABB, 0);
        lsu_op(0, 2'd1, 1, 32'h102, 0, 4'b0000, 0, 32'h00008899, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_loads();
        test_lsu_errors();
        test_stores();
        test_fetch();
        test_starve();
        test_reset_in_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the hart's single synchronous memory port between instruction fetch and the load/store unit. Each cycle it arbitrates, drives one access, and returns read data or an error to the winner one cycle later. It also performs byte-lane handling for loads and stores: strobe generation, lane replication, extraction and sign/zero extension. LSU wins by default, and a starvation guard bounds how long fetch can be locked out.

## Interface
- XLEN, 32, data/address width; only 32 is supported.
- STARVE_LIMIT, 4, consecutive contended LSU grants before fetch is forced through; must be at least 1.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch access request, held until fetch_ack.
- fetch_addr  in  XLEN  fetch byte address.
- fetch_ack  out  1  one-cycle completion pulse.
- fetch_err  out  1  with fetch_ack: misaligned fetch, no memory access made.
- fetch_rdata  out  XLEN  instruction word, valid with fetch_ack when fetch_err=0.
- lsu_req  in  1  LSU request, held stable until lsu_ack.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_width  in  2  0 byte, 1 halfword, 2 word, 3 reserved (error).
- lsu_unsigned  in  1  loads only: zero-extend instead of sign-extend.
- lsu_addr  in  XLEN  byte address.
- lsu_wdata  in  XLEN  store data, right-aligned.
- lsu_ack  out  1  one-cycle completion pulse.
- lsu_err  out  1  with lsu_ack: misaligned or reserved width, no memory access made.
- lsu_rdata  out  XLEN  extended load data, valid with lsu_ack for loads with lsu_err=0.
- mem_en  out  1  access strobe.
- mem_we  out  1  write enable; only valid with mem_en.
- mem_wstrb  out  4  byte lane enables for writes; bit i covers bits [8i+7:8i].
- mem_addr  out  XLEN  word address with bits [1:0] forced to 0.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_rdata  in  XLEN  read data, valid the cycle after mem_en.

## Operation
- FSM states: IDLE and RESP. Reset puts the FSM in IDLE.
- **IDLE:**
  - If any request is present, select a winner, drive the mem_* outputs combinationally from the winner's inputs, register the winner identity, error flag, byte offset, width and unsigned flag, then go to RESP.
  - With no request, stay in IDLE.
- **RESP:**
  - Pulse the winner's ack (and err if the error flag is set).
  - Present the extracted read data.
  - Return to IDLE. New requests are never accepted while in RESP.
- **Priority:**
  - With one request present, that requester wins.
  - With both present, LSU wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- **starve_cnt:**
  - Increments on an LSU grant made while fetch_req=1.
  - Clears on any fetch grant, or on an LSU grant made while fetch_req=0.
  - Saturates at STARVE_LIMIT.
- **Errors:**
  - Fetch: error when fetch_addr[1:0] != 0.
  - LSU: error when halfword has addr[0]=1, word has addr[1:0] != 0, or width is 3.
  - Error winners still take the grant and go through RESP, but mem_en=0 in the issue cycle.
- **Stores:**
  - byte: wstrb = 1 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - halfword: wstrb = 0011 or 1100, wdata = {2{wdata[15:0]}}.
  - word: wstrb = 1111, wdata passed through.
- **Loads:**
  - Shift mem_rdata right by 8*offset.
  - Truncate to the registered width.
  - Sign-extend, or zero-extend when the unsigned flag is set.
  - mem_wstrb=0 on reads.
- **Fetch:** always a word read with mem_we=0; fetch_rdata = mem_rdata.
- **Reset values:** every output is 0 (all rdata outputs 0, all mem_* outputs 0). starve_cnt = 0. All registered winner fields = 0.

## Timing
- Request sampled in IDLE at cycle T; the access issues in T.
- ack and rdata appear at T+1. Latency is 1 cycle, and throughput is one access per 2 cycles.
- A requester holding req at T+2 is treated as making a new request.
- Outputs are 0 when not active: ack, err and rdata are 0 outside RESP; mem_* outputs are 0 outside an issuing IDLE cycle.
- Reset asserted during RESP: the pending ack is never emitted, and the FSM returns to IDLE.
- A request change during RESP has no effect; only inputs sampled in IDLE matter.

## Test plan
- Word at 0x100 = 0x8899AABB. LSU byte load at 0x103, signed → lsu_ack at T+1, lsu_rdata=0xFFFFFF88. Same load with lsu_unsigned=1 → 0x00000088.
- LSU halfword load at 0x102, unsigned → 0x00008899. Halfword load at 0x101 → lsu_err=1 with lsu_ack, and mem_en stays 0.
- LSU byte store at 0x101 with wdata=0x000000CC → in the issue cycle: mem_en=1, mem_we=1, mem_wstrb=0010, mem_wdata=0xCCCCCCCC, mem_addr=0x100.
- fetch_req and lsu_req held continuously, STARVE_LIMIT=4 → grant order LSU, LSU, LSU, LSU, fetch, then repeats; fetch is never starved for more than 4 grants.
- Fetch at 0x00000006 → fetch_err=1 with fetch_ack, and no mem_en.
- rst pulsed in the RESP cycle of a fetch → no fetch_ack; all outputs 0; the next request is granted normally from IDLE.
